// File: rtl/piezo_pkg.sv
`default_nettype none
// piezo_pkg: state/note types, note periods and tune ROMs shared by piezo_sched.
// FAST_SIM_EN selects a 16-clock duration unit; the default unit is 65536 clocks.
package piezo_pkg;

`ifdef FAST_SIM_EN
  localparam int DUR_SHIFT_DEF = 4;
`else
  localparam int DUR_SHIFT_DEF = 16;
`endif

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_PLAY = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  typedef struct packed {
    logic [15:0] period;
    logic [9:0]  dur;
  } note_t;

  localparam logic [15:0] G6   = 16'd31888;
  localparam logic [15:0] C7   = 16'd23889;
  localparam logic [15:0] E7   = 16'd18961;
  localparam logic [15:0] G7   = 16'd15944;
  localparam logic [15:0] REST = 16'd0;

  // Tune index matches the grant bit position.
  localparam logic [1:0] TUNE_ERR    = 2'd0;
  localparam logic [1:0] TUNE_CHARGE = 2'd1;
  localparam logic [1:0] TUNE_DONE   = 2'd2;

  localparam logic [2:0] LEN_ERR    = 3'd3;
  localparam logic [2:0] LEN_CHARGE = 3'd6;
  localparam logic [2:0] LEN_DONE   = 3'd2;

  function automatic note_t tune_note(input logic [1:0] tune, input logic [2:0] idx);
    note_t n;
    n = '{period: REST, dur: 10'd1};
    case (tune)
      TUNE_ERR: case (idx)
        3'd0:    n = '{period: G6,   dur: 10'd64};
        3'd1:    n = '{period: REST, dur: 10'd64};
        default: n = '{period: G6,   dur: 10'd64};
      endcase
      TUNE_CHARGE: case (idx)
        3'd0:    n = '{period: G6, dur: 10'd128};
        3'd1:    n = '{period: C7, dur: 10'd128};
        3'd2:    n = '{period: E7, dur: 10'd128};
        3'd3:    n = '{period: G7, dur: 10'd192};
        3'd4:    n = '{period: E7, dur: 10'd64};
        default: n = '{period: G7, dur: 10'd512};
      endcase
      default: case (idx)
        3'd0:    n = '{period: C7, dur: 10'd128};
        default: n = '{period: G7, dur: 10'd128};
      endcase
    endcase
    return n;
  endfunction

  function automatic logic [2:0] tune_len(input logic [1:0] tune);
    case (tune)
      TUNE_ERR:    return LEN_ERR;
      TUNE_CHARGE: return LEN_CHARGE;
      default:     return LEN_DONE;
    endcase
  endfunction

  function automatic logic [2:0] prio_pick(input logic [2:0] pend);
    if (pend[0])      return 3'b001;
    else if (pend[1]) return 3'b010;
    else if (pend[2]) return 3'b100;
    else              return 3'b000;
  endfunction

  function automatic logic [1:0] onehot_to_tune(input logic [2:0] oh);
    if (oh[0])      return TUNE_ERR;
    else if (oh[1]) return TUNE_CHARGE;
    else            return TUNE_DONE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tone_gen.sv
`default_nettype none
// tone_gen: phase-aligned square wave; both outputs low while period is zero.
module tone_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] period,
  input  logic        restart,
  output logic        piezo,
  output logic        piezo_n
);

  logic [14:0] cnt_q, cnt_d;
  logic        piezo_q, piezo_d;
  logic        piezo_n_q, piezo_n_d;
  logic [14:0] half;

  assign half = period[15:1];

  always_comb begin
    cnt_d     = cnt_q + 15'd1;
    piezo_d   = piezo_q;
    piezo_n_d = piezo_n_q;
    if (restart || (period == 16'd0)) begin
      cnt_d     = '0;
      piezo_d   = 1'b0;
      piezo_n_d = (period != 16'd0);
    end else if (cnt_q == half - 15'd1) begin
      cnt_d     = '0;
      piezo_d   = ~piezo_q;
      piezo_n_d = piezo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      piezo_q   <= 1'b0;
      piezo_n_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      piezo_q   <= piezo_d;
      piezo_n_q <= piezo_n_d;
    end
  end

  assign piezo   = piezo_q;
  assign piezo_n = piezo_n_q;

endmodule
`default_nettype wire

// File: rtl/piezo_sched.sv
`default_nettype none
// piezo_sched: three-tune priority scheduler driving a piezo via tone_gen.
// Duration unit defaults from FAST_SIM_EN through piezo_pkg::DUR_SHIFT_DEF.
module piezo_sched
  import piezo_pkg::*;
#(
  parameter int DUR_SHIFT = DUR_SHIFT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_err,
  input  logic       req_charge,
  input  logic       req_done,
  input  logic       stop,
  output logic       piezo,
  output logic       piezo_n,
  output logic       busy,
  output logic [2:0] grant
);

  state_e                 state_q, state_d;
  logic [2:0]             pend_q, pend_d;
  logic [2:0]             grant_q, grant_d;
  logic [1:0]             tune_q, tune_d;
  logic [2:0]             idx_q, idx_d;
  logic [9:0]             units_q, units_d;
  logic [DUR_SHIFT-1:0]   pre_q, pre_d;
  logic [15:0]            period_q, period_d;
  logic                   busy_q, busy_d;
  logic                   restart;
  logic [2:0]             req_vec, pick, clr;
  note_t                  nt;

  assign req_vec = {req_done, req_charge, req_err};
  assign pick    = prio_pick(pend_q);

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    tune_d   = tune_q;
    idx_d    = idx_q;
    units_d  = units_q;
    pre_d    = pre_q + 1'b1;
    period_d = period_q;
    restart  = 1'b0;
    clr      = '0;
    nt       = '0;
    case (state_q)
      ST_IDLE: begin
        pre_d = '0;
        if (|pend_q) begin
          state_d = ST_LOAD;
          grant_d = pick;
          clr     = pick;
          tune_d  = onehot_to_tune(pick);
        end
      end
      ST_LOAD: begin
        nt       = tune_note(tune_q, 3'd0);
        period_d = nt.period;
        units_d  = nt.dur;
        idx_d    = 3'd0;
        pre_d    = '0;
        restart  = 1'b1;
        state_d  = ST_PLAY;
      end
      ST_PLAY: begin
        // Prescaler wraps to zero on its own, so every note and the gap start aligned.
        if (pre_q == '1) begin
          if (units_q == 10'd1) begin
            if (idx_q == tune_len(tune_q) - 3'd1) begin
              state_d  = ST_GAP;
              period_d = '0;
            end else begin
              nt       = tune_note(tune_q, idx_q + 3'd1);
              idx_d    = idx_q + 3'd1;
              period_d = nt.period;
              units_d  = nt.dur;
              restart  = 1'b1;
            end
          end else begin
            units_d = units_q - 10'd1;
          end
        end
      end
      default: begin
        if (pre_q == '1) begin
          if (|pend_q) begin
            state_d = ST_LOAD;
            grant_d = pick;
            clr     = pick;
            tune_d  = onehot_to_tune(pick);
          end else begin
            state_d = ST_IDLE;
            grant_d = '0;
          end
        end
      end
    endcase

    // A request landing on its own grant cycle survives the clear and re-queues.
    pend_d = (pend_q & ~clr) | req_vec;

    if (stop) begin
      state_d  = ST_IDLE;
      pend_d   = '0;
      grant_d  = '0;
      idx_d    = '0;
      units_d  = '0;
      pre_d    = '0;
      period_d = '0;
      restart  = 1'b0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pend_q   <= '0;
      grant_q  <= '0;
      tune_q   <= '0;
      idx_q    <= '0;
      units_q  <= '0;
      pre_q    <= '0;
      period_q <= '0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      grant_q  <= grant_d;
      tune_q   <= tune_d;
      idx_q    <= idx_d;
      units_q  <= units_d;
      pre_q    <= pre_d;
      period_q <= period_d;
      busy_q   <= busy_d;
    end
  end

  tone_gen u_tone_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .period  (period_d),
    .restart (restart),
    .piezo   (piezo),
    .piezo_n (piezo_n)
  );

  assign busy  = busy_q;
  assign grant = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_piezo_sched.sv
`default_nettype none
// tb_piezo_sched: directed checks of piezo_sched with a 16-clock duration unit,
// plus a 65536-clock-unit instance used to measure a full G6 half-period.
module tb_piezo_sched;

  logic       clk = 1'b0;
  logic       rst_n, req_err, req_charge, req_done, stop;
  logic       piezo, piezo_n, busy;
  logic [2:0] grant;
  logic       s_rst_n, s_req_charge;
  logic       s_piezo, s_piezo_n, s_busy;
  logic [2:0] s_grant;
  int         cyc = 0;
  int         tests = 0;
  int         fails = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  piezo_sched #(.DUR_SHIFT(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_err(req_err), .req_charge(req_charge),
    .req_done(req_done), .stop(stop), .piezo(piezo), .piezo_n(piezo_n),
    .busy(busy), .grant(grant)
  );

  piezo_sched #(.DUR_SHIFT(16)) dut_slow (
    .clk(clk), .rst_n(s_rst_n), .req_err(1'b0), .req_charge(s_req_charge),
    .req_done(1'b0), .stop(1'b0), .piezo(s_piezo), .piezo_n(s_piezo_n),
    .busy(s_busy), .grant(s_grant)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) step(1);
  endtask

  // Drive {done,charge,err} for one edge; c0 is the cycle count of the sampling edge.
  task automatic pulse(input logic [2:0] r, output int c0);
    {req_done, req_charge, req_err} = r;
    step(1);
    {req_done, req_charge, req_err} = 3'b000;
    c0 = cyc;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step(1);
    stop = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_grant"}, grant, 0);
    check({tag, "_piezo"}, piezo, 0);
    check({tag, "_piezo_n"}, piezo_n, 0);
  endtask

  initial begin
    int c0, e2, f, d, n;
    rst_n = 1'b0; s_rst_n = 1'b0;
    {req_done, req_charge, req_err} = 3'b000;
    stop = 1'b0; s_req_charge = 1'b0;
    step(3);
    check_idle("reset");
    rst_n = 1'b1; s_rst_n = 1'b1;
    step(2);
    check_idle("post_reset");

    // Single charge tune; the slow instance measures the G6 half-period alongside.
    fork
      begin
        pulse(3'b010, c0);
        e2 = c0 + 2;
        step(1);
        check("chg_grant", grant, 3'b010);
        check("chg_busy", busy, 1);
        step(1);
        check("chg_n0_piezo", piezo, 0);
        check("chg_n0_piezo_n", piezo_n, 1);
        wait_to(e2 + 10240);
        check("chg_n5_start_n", piezo_n, 1);
        wait_to(e2 + 18211);
        check("chg_n5_before_edge", piezo, 0);
        step(1);
        check("chg_n5_first_edge", piezo, 1);
        check("chg_n5_first_edge_n", piezo_n, 0);
        wait_to(e2 + 18432);
        check("chg_gap_busy", busy, 1);
        check("chg_gap_piezo", piezo, 0);
        check("chg_gap_piezo_n", piezo_n, 0);
        while (busy && cyc < c0 + 20000) step(1);
        d = cyc - c0;
        check("chg_busy_drop", (d >= 18449 && d <= 18451) ? 32'd18450 : d, 18450);
        check("chg_end_grant", grant, 0);
      end
      begin
        s_req_charge = 1'b1;
        step(1);
        s_req_charge = 1'b0;
        step(2);
        check("slow_start_n", s_piezo_n, 1);
        n = 0;
        while (!s_piezo && n < 20000) begin
          step(1);
          n++;
        end
        check("slow_half_period", n, 15944);
        s_rst_n = 1'b0;
        step(1);
        check("slow_reset_busy", s_busy, 0);
        check("slow_reset_piezo", s_piezo, 0);
      end
    join
    step(3);

    // Done and charge together: charge first, then done after a 16-clock gap.
    pulse(3'b110, c0);
    e2 = c0 + 2;
    step(1);
    check("dc_grant_first", grant, 3'b010);
    wait_to(e2 + 18440);
    check("dc_gap_piezo_n", piezo_n, 0);
    check("dc_gap_busy", busy, 1);
    wait_to(e2 + 18447);
    check("dc_gap_end_grant", grant, 3'b010);
    step(1);
    check("dc_done_grant", grant, 3'b100);
    step(1);
    check("dc_done_piezo_n", piezo_n, 1);
    do_stop();
    check_idle("dc_stop");
    step(3);

    // Error requested during charge note 2 waits, then plays with a silent middle rest.
    pulse(3'b010, c0);
    e2 = c0 + 2;
    wait_to(e2 + 4999);
    req_err = 1'b1;
    step(1);
    req_err = 1'b0;
    check("err_nopreempt_grant", grant, 3'b010);
    wait_to(e2 + 18212);
    check("err_chg_last_edge", piezo, 1);
    wait_to(e2 + 18448);
    check("err_grant", grant, 3'b001);
    f = e2 + 18449;
    wait_to(f + 1023);
    check("err_n0_piezo_n", piezo_n, 1);
    step(1);
    check("err_rest_piezo", piezo, 0);
    check("err_rest_piezo_n", piezo_n, 0);
    wait_to(f + 2047);
    check("err_rest_end_piezo_n", piezo_n, 0);
    step(1);
    check("err_n2_piezo_n", piezo_n, 1);
    do_stop();
    step(3);

    // Stop with done pending, coinciding with a new error request.
    pulse(3'b110, c0);
    wait_to(c0 + 100);
    stop = 1'b1; req_err = 1'b1;
    step(1);
    stop = 1'b0; req_err = 1'b0;
    check_idle("stop");
    step(40);
    check("stop_no_replay_busy", busy, 0);
    check("stop_no_replay_grant", grant, 0);

    // Reset pulse mid-tune with done pending.
    pulse(3'b010, c0);
    wait_to(c0 + 102);
    pulse(3'b100, d);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    check_idle("midreset");
    step(60);
    check("midreset_no_resume", busy, 0);

    // Charge re-requested during its own LOAD cycle plays twice.
    pulse(3'b010, c0);
    e2 = c0 + 2;
    step(1);
    check("rep_load_grant", grant, 3'b010);
    req_charge = 1'b1;
    step(1);
    req_charge = 1'b0;
    wait_to(e2 + 18440);
    check("rep_gap_busy", busy, 1);
    check("rep_gap_piezo_n", piezo_n, 0);
    wait_to(e2 + 18448);
    check("rep_second_grant", grant, 3'b010);
    step(1);
    check("rep_second_start_n", piezo_n, 1);
    do_stop();
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
